// File: rtl/metaballs_vga_out.sv
// VGA output stage for the metaballs renderer: aligns syncs/blanking to the pixel
// pipeline, maps 2-bit intensity through a frame-synchronous cycling palette.
module metaballs_vga_out #(
    parameter int unsigned SYNC_DELAY     = 2,
    parameter int unsigned PALETTE_FRAMES = 32
) (
    input  logic       clk_50mhz,
    input  logic       reset_n,
    input  logic       h_sync,
    input  logic       v_sync,
    input  logic       display,
    input  logic [1:0] pix,
    input  logic       cycle_en,
    input  logic       palette_step,
    output logic [1:0] vga_r,
    output logic [1:0] vga_g,
    output logic [1:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [1:0] palette_idx
);

    localparam logic [7:0] CntMax = 8'(PALETTE_FRAMES - 1);

    logic hs_dly, vs_dly, de_dly;

    generate
        if (SYNC_DELAY == 0) begin : g_nodly
            assign hs_dly = h_sync;
            assign vs_dly = v_sync;
            assign de_dly = display;
        end else begin : g_dly
            logic [SYNC_DELAY-1:0] hs_pipe_q, vs_pipe_q, de_pipe_q;

            always_ff @(posedge clk_50mhz or negedge reset_n) begin
                if (!reset_n) begin
                    hs_pipe_q <= '1;
                    vs_pipe_q <= '1;
                    de_pipe_q <= '0;
                end else begin
                    hs_pipe_q[0] <= h_sync;
                    vs_pipe_q[0] <= v_sync;
                    de_pipe_q[0] <= display;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        hs_pipe_q[i] <= hs_pipe_q[i-1];
                        vs_pipe_q[i] <= vs_pipe_q[i-1];
                        de_pipe_q[i] <= de_pipe_q[i-1];
                    end
                end
            end

            assign hs_dly = hs_pipe_q[SYNC_DELAY-1];
            assign vs_dly = vs_pipe_q[SYNC_DELAY-1];
            assign de_dly = de_pipe_q[SYNC_DELAY-1];
        end
    endgenerate

    logic       vs_in_q;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [1:0] idx_q, idx_d;
    logic       pend_q, pend_d;
    logic       frame_tick;
    logic       auto_adv;

    assign frame_tick = vs_in_q & ~v_sync;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        auto_adv    = 1'b0;
        if (frame_tick) begin
            // A step request landing on the tick cycle is consumed by this tick.
            pend_d = 1'b0;
            if (cycle_en) begin
                if (frame_cnt_q == CntMax) begin
                    frame_cnt_d = 8'd0;
                    auto_adv    = 1'b1;
                end else begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            if (auto_adv || pend_q || palette_step) begin
                idx_d = idx_q + 2'd1;
            end
        end else if (palette_step) begin
            pend_d = 1'b1;
        end
    end

    logic [5:0] lut_rgb;

    always_comb begin
        lut_rgb = 6'b00_00_00;
        case ({idx_q, pix})
            4'b00_01: lut_rgb = 6'b01_00_00;
            4'b00_10: lut_rgb = 6'b11_01_00;
            4'b00_11: lut_rgb = 6'b11_11_10;
            4'b01_01: lut_rgb = 6'b00_00_01;
            4'b01_10: lut_rgb = 6'b00_01_11;
            4'b01_11: lut_rgb = 6'b10_11_11;
            4'b10_01: lut_rgb = 6'b00_01_00;
            4'b10_10: lut_rgb = 6'b01_11_00;
            4'b10_11: lut_rgb = 6'b10_11_10;
            4'b11_01: lut_rgb = 6'b01_01_01;
            4'b11_10: lut_rgb = 6'b10_10_10;
            4'b11_11: lut_rgb = 6'b11_11_11;
            default:  lut_rgb = 6'b00_00_00;
        endcase
    end

    logic [5:0] rgb_q;
    logic       hsync_q, vsync_q;

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            vs_in_q     <= 1'b1;
            frame_cnt_q <= 8'd0;
            idx_q       <= 2'd0;
            pend_q      <= 1'b0;
            rgb_q       <= 6'd0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
        end else begin
            vs_in_q     <= v_sync;
            frame_cnt_q <= frame_cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            rgb_q       <= de_dly ? lut_rgb : 6'd0;
            hsync_q     <= hs_dly;
            vsync_q     <= vs_dly;
        end
    end

    assign vga_r       = rgb_q[5:4];
    assign vga_g       = rgb_q[3:2];
    assign vga_b       = rgb_q[1:0];
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign palette_idx = idx_q;

endmodule

// File: tb/tb_metaballs_vga_out.sv
// Directed bench for metaballs_vga_out: expectations queued at stimulus time and
// popped at each sample point.
module tb_metaballs_vga_out;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       h_sync = 1'b1, v_sync = 1'b1, display = 1'b0;
    logic [1:0] pix = 2'd0;
    logic       cycle_en = 1'b0, palette_step = 1'b0;
    logic [1:0] vga_r, vga_g, vga_b, palette_idx;
    logic       vga_hsync, vga_vsync;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    metaballs_vga_out #(
        .SYNC_DELAY     (2),
        .PALETTE_FRAMES (2)
    ) dut (
        .clk_50mhz    (clk),
        .reset_n      (reset_n),
        .h_sync       (h_sync),
        .v_sync       (v_sync),
        .display      (display),
        .pix          (pix),
        .cycle_en     (cycle_en),
        .palette_step (palette_step),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .vga_hsync    (vga_hsync),
        .vga_vsync    (vga_vsync),
        .palette_idx  (palette_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    function automatic logic [7:0] rgb();
        return {2'b00, vga_r, vga_g, vga_b};
    endfunction

    // One frame boundary: v_sync low 4 cycles then high 4 cycles; idx checked after tick.
    task automatic frame(input string tag, input logic [1:0] exp_idx, input logic step_on_tick);
        v_sync = 1'b0;
        palette_step = step_on_tick;
        step();
        palette_step = 1'b0;
        push({6'd0, exp_idx});
        check(tag, {6'd0, palette_idx});
        step(); step();
        push(8'd0);
        check({tag, "_vsync"}, {7'd0, vga_vsync});
        step();
        v_sync = 1'b1;
        repeat (4) step();
    endtask

    logic [1:0] auto_seq [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

    initial begin
        // Asynchronous reset before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        push(8'h00); check("rst_rgb", rgb());
        push(8'h01); check("rst_hsync", {7'd0, vga_hsync});
        push(8'h01); check("rst_vsync", {7'd0, vga_vsync});
        push(8'h00); check("rst_idx", {6'd0, palette_idx});
        repeat (3) step();
        reset_n = 1'b1;
        repeat (4) step();

        // h_sync -> vga_hsync takes SYNC_DELAY+1 = 3 edges.
        h_sync = 1'b0;
        step(); push(8'h01); check("hs_lat1", {7'd0, vga_hsync});
        step(); push(8'h01); check("hs_lat2", {7'd0, vga_hsync});
        step(); push(8'h00); check("hs_lat3", {7'd0, vga_hsync});
        h_sync = 1'b1;
        repeat (3) step();

        // Visible area with pix 0 stays black, then one-cycle pix latency.
        display = 1'b1;
        pix = 2'd0;
        repeat (3) step();
        push(8'h00); check("pix0_black", rgb());
        pix = 2'd3; step(); push(8'h3e); check("fire_l3", rgb());
        pix = 2'd1; step(); push(8'h10); check("fire_l1", rgb());
        pix = 2'd2; step(); push(8'h34); check("fire_l2", rgb());

        // Blanking follows display with SYNC_DELAY+1 latency.
        pix = 2'd3; step();
        display = 1'b0;
        step(); push(8'h3e); check("blank_d1", rgb());
        step(); push(8'h3e); check("blank_d2", rgb());
        step(); push(8'h00); check("blank_d3", rgb());
        step(); push(8'h00); check("blank_d4", rgb());

        // Auto cycling every 2 frames.
        cycle_en = 1'b1;
        for (int i = 0; i < 8; i++) frame($sformatf("auto%0d", i), auto_seq[i], 1'b0);

        // Manual steps: two requests in one frame give one advance.
        cycle_en = 1'b0;
        palette_step = 1'b1; step(); palette_step = 1'b0;
        step();
        palette_step = 1'b1; step(); palette_step = 1'b0;
        push(8'h00); check("man_hold", {6'd0, palette_idx});
        frame("man_tick", 2'd1, 1'b0);
        frame("man_idle", 2'd1, 1'b0);
        frame("coinc_tick", 2'd2, 1'b1);
        frame("coinc_after", 2'd2, 1'b0);

        // Auto-advance coinciding with a pending step advances exactly once.
        cycle_en = 1'b1;
        frame("sim_pre", 2'd2, 1'b0);
        palette_step = 1'b1; step(); palette_step = 1'b0;
        frame("sim_both", 2'd3, 1'b0);
        display = 1'b1;
        pix = 2'd2;
        repeat (3) step();
        push(8'h2a); check("mono_l2", rgb());

        // Mid-frame asynchronous reset.
        h_sync = 1'b0;
        repeat (4) step();
        push(8'h00); check("pre_rst_hsync", {7'd0, vga_hsync});
        #2 reset_n = 1'b0;
        #1;
        push(8'h00); check("mid_rst_rgb", rgb());
        push(8'h01); check("mid_rst_hsync", {7'd0, vga_hsync});
        push(8'h01); check("mid_rst_vsync", {7'd0, vga_vsync});
        push(8'h00); check("mid_rst_idx", {6'd0, palette_idx});
        step();
        reset_n = 1'b1;
        h_sync = 1'b1;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
